uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser_if.sv | 29 ++
 rtl/uart_frame_parser.sv | 158 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input, held-frame handshake and payload read port of the UART frame parser.
// The parser connects through the slave modport; the upstream receiver and the consumer use master.
interface uart_frame_parser_if #(
   parameter int MAX_LEN = 16
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0]    rx_data;
   logic          rx_done;
   logic          frame_valid;
   logic [7:0]    frame_cmd;
   logic [7:0]    frame_len;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          frame_ack;
   logic          err_stb;
   logic [1:0]    err_code;
   logic [7:0]    drop_cnt;

   modport slave (
      input  rx_data, rx_done, rd_addr, frame_ack,
      output frame_valid, frame_cmd, frame_len, rd_data, err_stb, err_code, drop_cnt
   );

   modport master (
      output rx_data, rx_done, rd_addr, frame_ack,
      input  frame_valid, frame_cmd, frame_len, rd_data, err_stb, err_code, drop_cnt
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from UART bytes, holds a validated frame for a
// consumer and reports bad-length, checksum and inter-byte timeout errors with a strobe.
module uart_frame_parser #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 4000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_frame_parser_if.slave   bus
);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int IW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {HUNT, CMD, LEN, PAY, CHK, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [7:0]    cmd_reg, cmd_next;
   logic [7:0]    len_reg, len_next;
   logic [7:0]    chk_reg, chk_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          err_stb_reg, err_stb_next;
   logic [1:0]    err_code_reg, err_code_next;
   logic [7:0]    drop_reg, drop_next;
   logic [7:0]    rd_data_reg;
   logic          buf_we;
   logic          in_frame;
   logic          timer_expire;
   logic          rd_in_range;

   logic [7:0]    buf_mem [MAX_LEN];

   assign in_frame     = (state_reg == CMD) || (state_reg == LEN) ||
                         (state_reg == PAY) || (state_reg == CHK);
   // Fires on the edge at which the idle count would reach TIMEOUT_CYCLES-1; a byte on that
   // same edge wins and restarts the count.
   assign timer_expire = in_frame && !bus.rx_done && (timer_reg == TW'(TIMEOUT_CYCLES - 2));
   assign rd_in_range  = (32'(bus.rd_addr) < 32'(MAX_LEN));

   always_comb begin
      state_next    = state_reg;
      cmd_next      = cmd_reg;
      len_next      = len_reg;
      chk_next      = chk_reg;
      idx_next      = idx_reg;
      timer_next    = '0;
      err_stb_next  = 1'b0;
      err_code_next = err_code_reg;
      drop_next     = drop_reg;
      buf_we        = 1'b0;

      if (in_frame && !bus.rx_done)
         timer_next = timer_reg + TW'(1);

      case (state_reg)
         HUNT: begin
            if (bus.rx_done && bus.rx_data == SYNC_BYTE)
               state_next = CMD;
         end
         CMD: begin
            if (bus.rx_done) begin
               cmd_next   = bus.rx_data;
               chk_next   = bus.rx_data;
               state_next = LEN;
            end
         end
         LEN: begin
            if (bus.rx_done) begin
               if (bus.rx_data > 8'(MAX_LEN)) begin
                  err_stb_next  = 1'b1;
                  err_code_next = 2'd1;
                  state_next    = HUNT;
               end else begin
                  len_next   = bus.rx_data;
                  chk_next   = chk_reg ^ bus.rx_data;
                  idx_next   = '0;
                  state_next = (bus.rx_data == 8'h00) ? CHK : PAY;
               end
            end
         end
         PAY: begin
            if (bus.rx_done) begin
               buf_we   = 1'b1;
               chk_next = chk_reg ^ bus.rx_data;
               idx_next = idx_reg + IW'(1);
               if (32'(idx_reg) + 32'd1 == 32'(len_reg))
                  state_next = CHK;
            end
         end
         CHK: begin
            if (bus.rx_done) begin
               if (bus.rx_data == chk_reg) begin
                  state_next = HOLD;
               end else begin
                  err_stb_next  = 1'b1;
                  err_code_next = 2'd2;
                  state_next    = HUNT;
               end
            end
         end
         HOLD: begin
            if (bus.rx_done && drop_reg != 8'hFF)
               drop_next = drop_reg + 8'd1;
            if (bus.frame_ack)
               state_next = HUNT;
         end
         default: state_next = HUNT;
      endcase

      if (timer_expire) begin
         err_stb_next  = 1'b1;
         err_code_next = 2'd3;
         state_next    = HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= HUNT;
         cmd_reg      <= '0;
         len_reg      <= '0;
         chk_reg      <= '0;
         idx_reg      <= '0;
         timer_reg    <= '0;
         err_stb_reg  <= 1'b0;
         err_code_reg <= '0;
         drop_reg     <= '0;
         rd_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         cmd_reg      <= cmd_next;
         len_reg      <= len_next;
         chk_reg      <= chk_next;
         idx_reg      <= idx_next;
         timer_reg    <= timer_next;
         err_stb_reg  <= err_stb_next;
         err_code_reg <= err_code_next;
         drop_reg     <= drop_next;
         rd_data_reg  <= rd_in_range ? buf_mem[bus.rd_addr] : 8'h00;
      end
   end

   // Payload store; written only while collecting payload, so it stays frozen during HOLD.
   always_ff @(posedge clk) begin
      if (buf_we)
         buf_mem[idx_reg[AW-1:0]] <= bus.rx_data;
   end

   assign bus.frame_valid = (state_reg == HOLD);
   assign bus.frame_cmd   = cmd_reg;
   assign bus.frame_len   = len_reg;
   assign bus.rd_data     = rd_data_reg;
   assign bus.err_stb     = err_stb_reg;
   assign bus.err_code    = err_code_reg;
   assign bus.drop_cnt    = drop_reg;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: stimulus queues expected frames/errors, a monitor
// acting as consumer pops and compares whenever the parser presents a frame or an error.
module tb_uart_frame_parser;
   localparam int MAX_LEN = 16;
   localparam int T       = 4000;
   localparam int AW      = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

   uart_frame_parser #(
      .SYNC_BYTE(8'hA5),
      .MAX_LEN(MAX_LEN),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   logic          manual = 1'b0;
   logic          man_ack = 1'b0;
   logic          mon_ack = 1'b0;
   logic [AW-1:0] man_addr = '0;
   logic [AW-1:0] mon_addr = '0;

   assign bus.frame_ack = manual ? man_ack : mon_ack;
   assign bus.rd_addr   = manual ? man_addr : mon_addr;

   typedef struct {
      bit         is_err;
      logic [1:0] code;
      logic [7:0] cmd;
      logic [7:0] len;
      logic [7:0] pay [MAX_LEN];
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len,
                             input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
      exp_t e;
      e.is_err = 1'b0;
      e.code   = 2'd0;
      e.cmd    = cmd;
      e.len    = len;
      for (int i = 0; i < MAX_LEN; i++) e.pay[i] = 8'h00;
      e.pay[0] = p0;
      e.pay[1] = p1;
      e.pay[2] = p2;
      exp_q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code);
      exp_t e;
      e.is_err = 1'b1;
      e.code   = code;
      e.cmd    = 8'h00;
      e.len    = 8'h00;
      for (int i = 0; i < MAX_LEN; i++) e.pay[i] = 8'h00;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_done = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (bus.frame_valid && i < 300) begin
         tick();
         i++;
      end
      check("frame_released", 32'(bus.frame_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
      check({tag, "_err_stb"},     32'(bus.err_stb),     32'd0);
      check({tag, "_err_code"},    32'(bus.err_code),    32'd0);
      check({tag, "_frame_cmd"},   32'(bus.frame_cmd),   32'd0);
      check({tag, "_frame_len"},   32'(bus.frame_len),   32'd0);
      check({tag, "_rd_data"},     32'(bus.rd_data),     32'd0);
      check({tag, "_drop_cnt"},    32'(bus.drop_cnt),    32'd0);
   endtask

   // Monitor and consumer: compares every err_stb pulse and every newly held frame.
   initial begin
      exp_t e;
      bit   seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (bus.err_stb) begin
            if (exp_q.size() == 0) begin
               check("unexpected_err_stb", 32'(bus.err_stb), 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("error strobe: code=%0d", bus.err_code);
               check("err_kind", 32'(e.is_err), 32'd1);
               check("err_code", 32'(bus.err_code), 32'(e.code));
            end
            @(negedge clk);
            check("err_pulse_width", 32'(bus.err_stb), 32'd0);
         end else if (bus.frame_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'(bus.frame_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("frame: cmd=%02h len=%0d", bus.frame_cmd, bus.frame_len);
               check("frame_kind", 32'(e.is_err), 32'd0);
               check("frame_cmd", 32'(bus.frame_cmd), 32'(e.cmd));
               check("frame_len", 32'(bus.frame_len), 32'(e.len));
               if (!manual) begin
                  for (int i = 0; i < int'(e.len); i++) begin
                     mon_addr = AW'(i);
                     @(negedge clk);
                     check("payload", 32'(bus.rd_data), 32'(e.pay[i]));
                  end
                  mon_ack = 1'b1;
                  @(negedge clk);
                  mon_ack = 1'b0;
                  check("ack_release", 32'(bus.frame_valid), 32'd0);
                  seen = 1'b0;
               end
            end
         end else if (!bus.frame_valid) begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Three-byte frame, checksum 01^03^10^20^30 = 02
      push_frame(8'h01, 8'h03, 8'h10, 8'h20, 8'h30);
      send(8'hA5, 2); send(8'h01, 2); send(8'h03, 2);
      send(8'h10, 2); send(8'h20, 2); send(8'h30, 2);
      check("t1_valid_before_chk", 32'(bus.frame_valid), 32'd0);
      send(8'h02, 0);
      check("t1_valid_latency", 32'(bus.frame_valid), 32'd1);
      check("t1_cmd", 32'(bus.frame_cmd), 32'h01);
      check("t1_len", 32'(bus.frame_len), 32'd3);
      wait_idle();

      // Zero-length frame, then the same with a bad checksum
      push_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
      send(8'hA5, 2); send(8'h07, 2); send(8'h00, 2);
      send(8'h07, 0);
      check("t2_valid", 32'(bus.frame_valid), 32'd1);
      check("t2_len", 32'(bus.frame_len), 32'd0);
      wait_idle();
      push_err(2'd2);
      send(8'hA5, 2); send(8'h07, 2); send(8'h00, 2);
      send(8'h06, 0);
      check("t2_chk_err_stb", 32'(bus.err_stb), 32'd1);
      check("t2_chk_err_code", 32'(bus.err_code), 32'd2);
      repeat (3) tick();
      check("t2_no_valid", 32'(bus.frame_valid), 32'd0);

      // Oversized length, then a good frame (02^01^55 = 56)
      push_err(2'd1);
      send(8'hA5, 2); send(8'h02, 2);
      send(8'h11, 0);
      check("t3_len_err_stb", 32'(bus.err_stb), 32'd1);
      check("t3_len_err_code", 32'(bus.err_code), 32'd1);
      repeat (2) tick();
      push_frame(8'h02, 8'h01, 8'h55, 8'h00, 8'h00);
      send(8'hA5, 2); send(8'h02, 2); send(8'h01, 2); send(8'h55, 2);
      send(8'h56, 0);
      check("t3_valid", 32'(bus.frame_valid), 32'd1);
      wait_idle();

      // Inter-byte timeout inside payload
      push_err(2'd3);
      send(8'hA5, 2); send(8'h09, 2); send(8'h02, 2);
      send(8'hAA, 0);
      begin
         int k;
         k = 0;
         while (!bus.err_stb && k < T + 10) begin
            tick();
            k++;
         end
         check("t4_timeout_latency", 32'(k), 32'(T - 1));
         check("t4_timeout_code", 32'(bus.err_code), 32'd3);
      end
      repeat (3) tick();

      // Byte on the expiry edge prevents the timeout (09^02^AA^BB = 1A)
      push_frame(8'h09, 8'h02, 8'hAA, 8'hBB, 8'h00);
      send(8'hA5, 2); send(8'h09, 2); send(8'h02, 2);
      send(8'hAA, 0);
      repeat (T - 2) tick();
      send(8'hBB, 0);
      check("t4b_no_timeout", 32'(bus.err_stb), 32'd0);
      send(8'h1A, 0);
      check("t4b_valid", 32'(bus.frame_valid), 32'd1);
      wait_idle();

      // Held frame drops bytes, including one on the ack cycle (03^02^C3^3C = FE)
      manual = 1'b1;
      push_frame(8'h03, 8'h02, 8'hC3, 8'h3C, 8'h00);
      send(8'hA5, 2); send(8'h03, 2); send(8'h02, 2); send(8'hC3, 2); send(8'h3C, 2);
      send(8'hFE, 0);
      check("t5_valid", 32'(bus.frame_valid), 32'd1);
      man_addr = 4'd0; tick(); check("t5_rd0", 32'(bus.rd_data), 32'hC3);
      man_addr = 4'd1; tick(); check("t5_rd1", 32'(bus.rd_data), 32'h3C);
      send(8'h11, 1); send(8'h12, 1); send(8'h13, 1);
      check("t5_drop3", 32'(bus.drop_cnt), 32'd3);
      check("t5_still_held", 32'(bus.frame_valid), 32'd1);
      man_ack = 1'b1;
      bus.rx_data = 8'h22;
      bus.rx_done = 1'b1;
      tick();
      man_ack = 1'b0;
      bus.rx_done = 1'b0;
      check("t5_ack_release", 32'(bus.frame_valid), 32'd0);
      check("t5_drop_on_ack", 32'(bus.drop_cnt), 32'd4);
      tick();

      // Saturation: 300 bytes against a held frame (04^01^77 = 72)
      push_frame(8'h04, 8'h01, 8'h77, 8'h00, 8'h00);
      send(8'hA5, 2); send(8'h04, 2); send(8'h01, 2); send(8'h77, 2);
      send(8'h72, 0);
      check("t5s_valid", 32'(bus.frame_valid), 32'd1);
      for (int i = 0; i < 300; i++) send(8'(i), 0);
      check("t5s_drop_sat", 32'(bus.drop_cnt), 32'd255);
      check("t5s_cmd", 32'(bus.frame_cmd), 32'h04);
      check("t5s_len", 32'(bus.frame_len), 32'd1);
      man_addr = 4'd0; tick(); check("t5s_rd0", 32'(bus.rd_data), 32'h77);
      check("t5s_still_held", 32'(bus.frame_valid), 32'd1);
      man_ack = 1'b1; tick(); man_ack = 1'b0;
      check("t5s_release", 32'(bus.frame_valid), 32'd0);
      manual = 1'b0;
      tick();

      // Garbage before a frame (05^01^99 = 9D)
      send(8'h00, 2); send(8'hFF, 2); send(8'h5A, 2);
      check("t6_garbage_no_err", 32'(bus.err_stb), 32'd0);
      push_frame(8'h05, 8'h01, 8'h99, 8'h00, 8'h00);
      send(8'hA5, 2); send(8'h05, 2); send(8'h01, 2); send(8'h99, 2);
      send(8'h9D, 0);
      check("t6_valid", 32'(bus.frame_valid), 32'd1);
      wait_idle();

      // Reset mid-payload, then a fresh frame (06^02^12^34 = 22)
      send(8'hA5, 2); send(8'h01, 2); send(8'h03, 2); send(8'h10, 2);
      rst_n = 1'b0;
      tick(); tick();
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      tick();
      push_frame(8'h06, 8'h02, 8'h12, 8'h34, 8'h00);
      send(8'hA5, 2); send(8'h06, 2); send(8'h02, 2); send(8'h12, 2); send(8'h34, 2);
      send(8'h22, 0);
      check("t7_valid", 32'(bus.frame_valid), 32'd1);
      wait_idle();

      begin
         int w;
         w = 0;
         while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
         end
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
